// File: rtl/ada_wb_arbiter_pkg.sv
// Shared widths, the long-latency FIFO entry layout and a one-hot helper
// for the write-back arbiter and its FIFO.
package ada_wb_arbiter_pkg;

  localparam int ADA_REG_ADDR_W = 5;
  localparam int ADA_DATA_W     = 32;
  localparam int ADA_NUM_REGS   = 1 << ADA_REG_ADDR_W;

  localparam logic [ADA_REG_ADDR_W-1:0] ADA_ZERO_REG = '0;

  typedef struct packed {
    logic [ADA_REG_ADDR_W-1:0] addr;
    logic [ADA_DATA_W-1:0]     data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  // One-hot register mask; register 0 never appears in the scoreboard.
  function automatic logic [ADA_NUM_REGS-1:0] reg_mask(
    input logic [ADA_REG_ADDR_W-1:0] addr
  );
    logic [ADA_NUM_REGS-1:0] m;
    m = '0;
    if (addr != ADA_ZERO_REG) m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/ada_wb_fifo.sv
// Synchronous FIFO for long-latency results. Pointers carry an extra wrap
// bit so full and empty are told apart without a separate counter.
module ada_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A full FIFO refuses a push even when the same edge pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ada_wb_arbiter.sv
// Merges pipeline write-back and queued long-latency results into one
// registered register-file write, and tracks outstanding long-latency dests.
module ada_wb_arbiter
  import ada_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_addr,
  input  logic [31:0] pipe_data,
  input  logic        ll_valid,
  output logic        ll_ready,
  input  logic [4:0]  ll_addr,
  input  logic [31:0] ll_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  input  logic [4:0]  check_addr_a,
  input  logic [4:0]  check_addr_b,
  output logic        stall_a,
  output logic        stall_b,
  output logic [31:0] pending,
  output logic [4:0]  write_addr,
  output logic [31:0] write_data,
  output logic        we
);

  wb_entry_t   push_entry;
  wb_entry_t   head_entry;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        pipe_win;
  logic        out_ll;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [31:0] pending_q;

  // ll_valid/ll_ready: a result transfers on a rising edge where both are
  // high. ll_ready comes only from the registered full flag and rst, never
  // from ll_valid, so the producer may raise or drop ll_valid freely.
  assign ll_ready   = !fifo_full && !rst;
  assign push       = ll_valid && ll_ready;
  assign push_entry = '{addr: ll_addr, data: ll_data};

  // Writes to register 0 are dropped and must not starve the FIFO.
  assign pipe_win = pipe_we && (pipe_addr != ADA_ZERO_REG);
  assign pop      = !pipe_win && !fifo_empty;

  ada_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      we         <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      out_ll     <= 1'b0;
    end else if (pipe_win) begin
      we         <= 1'b1;
      write_addr <= pipe_addr;
      write_data <= pipe_data;
      out_ll     <= 1'b0;
    end else if (pop) begin
      we         <= (head_entry.addr != ADA_ZERO_REG);
      write_addr <= head_entry.addr;
      write_data <= head_entry.data;
      out_ll     <= 1'b1;
    end else begin
      we         <= 1'b0;
      out_ll     <= 1'b0;
    end
  end

  // The clear tracks the edge the register file actually takes the
  // long-latency value, so decode never sees a stale read in between.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid) set_mask = reg_mask(issue_addr);
    if (we && out_ll) clr_mask = reg_mask(write_addr);
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= (pending_q & ~clr_mask) | set_mask;
  end

  assign pending = pending_q;
  assign stall_a = pending_q[check_addr_a];
  assign stall_b = pending_q[check_addr_b];

endmodule

// File: tb/tb_ada_wb_arbiter.sv
// Directed scenarios plus random traffic for ada_wb_arbiter, checked each
// cycle against a queue-based behavioural model of the write-back rules.
module tb_ada_wb_arbiter;

  localparam int DEPTH = 2;
  localparam int W     = 37;

  logic        clk;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic [4:0]  check_addr_a;
  logic [4:0]  check_addr_b;
  logic        stall_a;
  logic        stall_b;
  logic [31:0] pending;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic        we;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] exp_q[$];
  bit           m_pend[32];
  logic         m_we;
  logic [4:0]   m_addr;
  logic [31:0]  m_data;
  logic         m_ll;

  ada_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .pipe_we      (pipe_we),
    .pipe_addr    (pipe_addr),
    .pipe_data    (pipe_data),
    .ll_valid     (ll_valid),
    .ll_ready     (ll_ready),
    .ll_addr      (ll_addr),
    .ll_data      (ll_data),
    .issue_valid  (issue_valid),
    .issue_addr   (issue_addr),
    .check_addr_a (check_addr_a),
    .check_addr_b (check_addr_b),
    .stall_a      (stall_a),
    .stall_b      (stall_b),
    .pending      (pending),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .we           (we)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pend_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One edge of the architectural rules, using the inputs sampled at the edge.
  task automatic model_step();
    logic [W-1:0] head;
    bit           room;
    room = (exp_q.size() < DEPTH) && !rst;
    if (rst) begin
      exp_q.delete();
      foreach (m_pend[i]) m_pend[i] = 0;
      m_we = 0; m_addr = '0; m_data = '0; m_ll = 0;
    end else begin
      if (m_we && m_ll) m_pend[m_addr] = 0;
      if (issue_valid && issue_addr != 0) m_pend[issue_addr] = 1;
      if (pipe_we && pipe_addr != 0) begin
        m_we = 1; m_addr = pipe_addr; m_data = pipe_data; m_ll = 0;
      end else if (exp_q.size() > 0) begin
        head   = exp_q.pop_front();
        m_addr = head[36:32];
        m_data = head[31:0];
        m_we   = (m_addr != 0);
        m_ll   = 1;
      end else begin
        m_we = 0; m_ll = 0;
      end
      if (ll_valid && room) exp_q.push_back({ll_addr, ll_data});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("we",         32'(we),         32'(m_we));
    check("write_addr", 32'(write_addr), 32'(m_addr));
    check("write_data", write_data,      m_data);
    check("pending",    pending,         pend_vec());
    check("ll_ready",   32'(ll_ready),   32'(!rst && exp_q.size() < DEPTH));
    check("stall_a",    32'(stall_a),    32'(m_pend[check_addr_a]));
    check("stall_b",    32'(stall_b),    32'(m_pend[check_addr_b]));
    check("we_reg0",    32'(we && write_addr == 0), 32'(0));
  endtask

  // Driver tasks
  task automatic idle();
    pipe_we = 0; pipe_addr = '0; pipe_data = '0;
    ll_valid = 0; ll_addr = '0; ll_data = '0;
    issue_valid = 0; issue_addr = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [4:0] wr_log[$];
  logic [4:0] exp_order[7];
  bit         acc;
  int         idx;
  logic [4:0] ll_dst[3];

  initial begin
    rst = 1; check_addr_a = '0; check_addr_b = '0;
    idle();
    m_we = 0; m_addr = '0; m_data = '0; m_ll = 0;
    foreach (m_pend[i]) m_pend[i] = 0;

    // Reset held with valid traffic offered
    ll_valid = 1; ll_addr = 5'd6; ll_data = 32'h1234;
    issue_valid = 1; issue_addr = 5'd6;
    ticks(3);
    check("rst_ready", 32'(ll_ready), 32'(0));
    check("rst_pend",  pending, 32'h0);
    idle();
    rst = 0;
    #1;
    check("ready_after_rst", 32'(ll_ready), 32'(1));

    // Single long-latency write to r7
    check_addr_a = 5'd7; check_addr_b = 5'd8;
    issue_valid = 1; issue_addr = 5'd7;
    tick();
    check("r7_pending", 32'(stall_a), 32'(1));
    idle();
    ll_valid = 1; ll_addr = 5'd7; ll_data = 32'hDEADBEEF;
    tick();
    check("r7_we_hs", 32'(we), 32'(0));
    idle();
    tick();
    check("r7_we",    32'(we), 32'(1));
    check("r7_addr",  32'(write_addr), 32'(7));
    check("r7_data",  write_data, 32'hDEADBEEF);
    check("r7_stall", 32'(stall_a), 32'(1));
    tick();
    check("r7_clear", 32'(stall_a), 32'(0));
    check("r7_pvec",  32'(pending[7]), 32'(0));
    ticks(2);

    // Pipeline priority while three long-latency results arrive
    ll_dst = '{5'd3, 5'd4, 5'd5};
    exp_order = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd3, 5'd4, 5'd5};
    wr_log.delete();
    idx = 0;
    for (int k = 0; k < 20 && (idx < 3 || k < 4); k++) begin
      pipe_we   = (k < 4);
      pipe_addr = 5'(10 + k);
      pipe_data = 32'hA000 + 32'(k);
      ll_valid  = (idx < 3);
      ll_addr   = (idx < 3) ? ll_dst[idx] : 5'd0;
      ll_data   = 32'hB000 + 32'(idx);
      acc = ll_valid && ll_ready;
      tick();
      if (acc) idx++;
      if (we) wr_log.push_back(write_addr);
    end
    check("prio_pushes", 32'(idx), 32'(3));
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (we) wr_log.push_back(write_addr);
    end
    check("prio_count", 32'(wr_log.size()), 32'(7));
    for (int k = 0; k < 7; k++)
      check("prio_order", (k < wr_log.size()) ? 32'(wr_log[k]) : 32'hFFFF_FFFF, 32'(exp_order[k]));

    // Pipeline write to r0 does not block a queued entry
    pipe_we = 1; pipe_addr = 5'd20; pipe_data = 32'h20;
    ll_valid = 1; ll_addr = 5'd9; ll_data = 32'h1;
    tick();
    idle();
    pipe_we = 1; pipe_addr = 5'd0; pipe_data = 32'hBAD0;
    tick();
    check("r0_drop_we",   32'(we), 32'(1));
    check("r0_drop_addr", 32'(write_addr), 32'(9));
    check("r0_drop_data", write_data, 32'h1);
    idle();
    ticks(2);

    // Set wins over a same-cycle clear on r12
    issue_valid = 1; issue_addr = 5'd12;
    tick();
    idle();
    ll_valid = 1; ll_addr = 5'd12; ll_data = 32'hC12;
    tick();
    idle();
    tick();
    check("r12_we", 32'(we && write_addr == 5'd12), 32'(1));
    issue_valid = 1; issue_addr = 5'd12;
    tick();
    check("r12_set_wins", 32'(pending[12]), 32'(1));
    idle();
    ticks(2);

    // Reset with two queued entries and pending r4/r7
    rst = 1; tick(); rst = 0;
    issue_valid = 1; issue_addr = 5'd4; tick();
    issue_addr = 5'd7; tick();
    idle();
    pipe_we = 1; pipe_addr = 5'd1; pipe_data = 32'h11;
    ll_valid = 1; ll_addr = 5'd4; ll_data = 32'h44;
    tick();
    pipe_addr = 5'd2; pipe_data = 32'h22;
    ll_addr = 5'd7; ll_data = 32'h77;
    tick();
    check("mid_pend",  pending, 32'h0000_0090);
    check("mid_full",  32'(ll_ready), 32'(0));
    idle();
    rst = 1;
    tick();
    rst = 0;
    check("mid_we",   32'(we), 32'(0));
    check("mid_clr",  pending, 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mid_no_late", 32'(we), 32'(0));
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 99) == 0);
      pipe_we      = ($urandom_range(0, 1) == 1);
      pipe_addr    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      pipe_data    = $urandom;
      ll_valid     = ($urandom_range(0, 2) != 0);
      ll_addr      = 5'($urandom_range(0, 31));
      ll_data      = $urandom;
      issue_valid  = ($urandom_range(0, 3) == 0);
      issue_addr   = 5'($urandom_range(0, 31));
      check_addr_a = 5'($urandom_range(0, 31));
      check_addr_b = 5'($urandom_range(0, 31));
      tick();
    end

    rst = 0;
    idle();
    ticks(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
